rvvi_net_event_sched: RTL and testbench
=======================================

// Module: rvvi_net_event_sched
//
// PURPOSE
//  Hardware scheduler for RVVI net-change events (interrupt lines, haltreq, etc.).
//  - Round-robin arbitrates NREQ requesters into one ordered event FIFO.
//  - Stamps each event with a time-slot number, then drains events to the RVVI
//    consumer through a valid/ready pop port.
//  - Keeps a shadow table of the last popped value per net, so the consumer can
//    query the current committed state of any net.
//
// PARAMETERS
//  NREQ     4   number of event requesters (>=1)
//  ID_W     6   net identifier width; shadow table holds 2**ID_W entries
//  VAL_W    32  net value width
//  DEPTH    16  FIFO entries (power of two, >=2)
//  SLOT_W   32  time-slot counter width
//
// PORTS
//  clk          in   1            interface clock
//  rst_n        in   1            asynchronous active-low reset
//  req_valid    in   NREQ         requester i presents an event
//  req_ready    out  NREQ         event from requester i accepted this cycle
//  req_id       in   NREQ*ID_W    net id, requester i in bits [i*ID_W +: ID_W]
//  req_value    in   NREQ*VAL_W   net value, same packing as req_id
//  slot_tick    in   1            simulation time advanced since previous cycle
//  pop_valid    out  1            FIFO head is valid
//  pop_ready    in   1            consumer takes the head this cycle
//  pop_id       out  ID_W         head net id
//  pop_value    out  VAL_W        head net value
//  pop_slot     out  SLOT_W       head time slot
//  count        out  $clog2(DEPTH)+1   current FIFO occupancy
//  qry_id       in   ID_W         shadow-table query address
//  qry_value    out  VAL_W        shadow[qry_id], combinational read
//
// BEHAVIOUR
//  Reset (async, rst_n low)
//  - FIFO empty: pop_valid=0, count=0, pop_id/pop_value/pop_slot=0.
//  - req_ready=0; RR pointer=0; vslot=0; tick_pend=0; every shadow entry=0.
//  - Reset asserted mid-transfer discards all queued events and shadow state.
//
//  Arbitration
//  - At most one grant per cycle.
//  - Search starts at index (last_grant+1) mod NREQ; after reset, at index 0.
//  - Define can_push = !full || (pop_valid && pop_ready).
//  - req_ready[g]=1 only for the winner g, and only when can_push.
//  - All other ready bits are 0; req_ready never asserts without req_valid.
//  - last_grant updates only on an accepted push.
//  - Requesters hold valid/id/value stable until ready.
//
//  Slot stamping
//  - eff = tick_pend | slot_tick.
//  - On a push, the entry slot = vslot + eff (mod 2**SLOT_W); vslot takes that
//    value; tick_pend clears.
//  - With no push: tick_pend |= slot_tick.
//  - Result: all events in one sim time step share a slot; the first event
//    after any tick gets the next slot. A push with no tick since the last
//    push reuses the previous slot.
//  - Wrap-around modulo 2**SLOT_W, no flag.
//
//  FIFO
//  - Circular buffer; head is registered.
//  - An event pushed into an empty FIFO appears on pop_valid the next cycle
//    (1-cycle latency).
//  - Push and pop in the same cycle: count unchanged, legal when full.
//  - Pop is ignored when empty.
//  - Order is strictly acceptance order.
//
//  Shadow table
//  - On a pop handshake: shadow[pop_id] <= pop_value.
//  - qry_value reads pre-update contents; a write lands the following cycle.
//
// STRUCTURE
//  - rvvi_pkg additions:
//    - typedef rvvi_net_evt_t {id, value, slot}, packed, sized by localparams.
//    - constant RVVI_NET_SLOT_W.
//  - Sub-module rvvi_rr_arbiter (NREQ, rotating priority, advance-on-accept).
//    It is also reused for future multi-hart retire arbitration.
//  - FIFO, slot counter and shadow table stay inline.
//
// TESTING
//  - Reset: drive rst_n=0 asynchronously mid-cycle with 3 events queued
//    -> pop_valid=0, count=0, qry_value=0 for all ids, all immediately.
//  - Single event: req0 {id=5, val=0x11}, no tick -> pop next cycle
//    {5, 0x11, slot=0}; after pop, qry_id=5 returns 0x11.
//  - Round robin: all 4 requesters valid for 8 cycles
//    -> grant order 0,1,2,3,0,1,2,3; pops in the same order.
//  - Slot stamping: push A; tick; push B, C; tick+push D (same cycle)
//    -> slots 0,1,1,2.
//    Then with vslot preset near 2**SLOT_W-1 (force), tick+push -> slot wraps to 0.
//  - Full FIFO:
//    - Fill DEPTH=16 with pop_ready=0 -> req_ready=0, count=16.
//    - Assert pop_ready -> push and pop complete in the same cycle, count stays 16.
//  - Shadow ordering: pop id=7 val=1, then id=7 val=2
//    -> qry_value(7) = 0, 1, 2 on consecutive cycles.

Source files
------------

// File: rtl/rvvi_net_event_sched_pkg.sv
// Shared types and default widths for the RVVI net-change event scheduler.
package rvvi_net_event_sched_pkg;

    localparam int RVVI_NET_ID_W   = 6;
    localparam int RVVI_NET_VAL_W  = 32;
    localparam int RVVI_NET_SLOT_W = 32;

    typedef struct packed {
        logic [RVVI_NET_ID_W-1:0]   id;
        logic [RVVI_NET_VAL_W-1:0]  value;
        logic [RVVI_NET_SLOT_W-1:0] slot;
    } rvvi_net_evt_t;

endpackage

// File: rtl/rvvi_net_event_sched_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant, search starts just after the last
// accepted winner; the pointer only moves when the grant is actually taken.
module rvvi_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] gnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic             found;

    always_comb begin
        gnt   = '0;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                gnt[(int'(ptr) + k) % NREQ] = 1'b1;
                win   = IDX_W'((int'(ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (adv && found)
            ptr <= (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
    end

endmodule

// File: rtl/rvvi_net_event_sched.sv
// RVVI net-change event scheduler: RR arbitration into an ordered FIFO with
// time-slot stamping, a registered pop head, and a per-net committed-value table.
module rvvi_net_event_sched
    import rvvi_net_event_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ID_W   = RVVI_NET_ID_W,
    parameter int VAL_W  = RVVI_NET_VAL_W,
    parameter int DEPTH  = 16,
    parameter int SLOT_W = RVVI_NET_SLOT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ID_W-1:0]    req_id,
    input  logic [NREQ*VAL_W-1:0]   req_value,
    input  logic                    slot_tick,
    output logic                    pop_valid,
    input  logic                    pop_ready,
    output logic [ID_W-1:0]         pop_id,
    output logic [VAL_W-1:0]        pop_value,
    output logic [SLOT_W-1:0]       pop_slot,
    output logic [$clog2(DEPTH):0]  count,
    input  logic [ID_W-1:0]         qry_id,
    output logic [VAL_W-1:0]        qry_value
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NIDS  = 2**ID_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [VAL_W-1:0]  value;
        logic [SLOT_W-1:0] slot;
    } evt_t;

    evt_t              mem [DEPTH];
    evt_t              head_q;
    evt_t              push_evt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [SLOT_W-1:0] vslot, slot_nxt;
    logic              tick_pend;
    logic [VAL_W-1:0]  shadow [NIDS];
    logic [NREQ-1:0]   gnt;
    logic              full, pop_fire, can_push, push;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign pop_valid = (cnt_q != '0);
    assign pop_fire  = pop_valid && pop_ready;
    // Reset gating keeps ready low for the whole time rst_n is held.
    assign can_push  = rst_n && (!full || pop_fire);
    assign push      = can_push && (|req_valid);
    assign req_ready = gnt & {NREQ{can_push}};
    assign slot_nxt  = vslot + SLOT_W'(tick_pend | slot_tick);
    assign rd_nxt    = rd_ptr + PTR_W'(pop_fire);

    rvvi_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .adv   (push),
        .gnt   (gnt)
    );

    always_comb begin
        push_evt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                push_evt.id    = req_id[i*ID_W +: ID_W];
                push_evt.value = req_value[i*VAL_W +: VAL_W];
            end
        end
        push_evt.slot = slot_nxt;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
            vslot     <= '0;
            tick_pend <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop_fire);
            // A push landing on the next head slot bypasses the memory.
            head_q <= (push && (wr_ptr == rd_nxt)) ? push_evt : mem[rd_nxt];
            if (push) begin
                vslot     <= slot_nxt;
                tick_pend <= 1'b0;
            end else begin
                tick_pend <= tick_pend | slot_tick;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NIDS; i++)
                shadow[i] <= '0;
        end else if (pop_fire) begin
            shadow[head_q.id] <= head_q.value;
        end
    end

    assign qry_value = shadow[qry_id];
    assign pop_id    = head_q.id;
    assign pop_value = head_q.value;
    assign pop_slot  = head_q.slot;
    assign count     = cnt_q;

endmodule

// File: tb/tb_rvvi_net_event_sched.sv
// Bench for rvvi_net_event_sched: directed scenarios plus randomized traffic,
// all checked each cycle against a queue-based behavioural model.
module tb_rvvi_net_event_sched;

    localparam int NREQ   = 4;
    localparam int ID_W   = 6;
    localparam int VAL_W  = 32;
    localparam int DEPTH  = 16;
    localparam int SLOT_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid, req_ready;
    logic [NREQ*ID_W-1:0]   req_id;
    logic [NREQ*VAL_W-1:0]  req_value;
    logic                   slot_tick, pop_valid, pop_ready;
    logic [ID_W-1:0]        pop_id, qry_id;
    logic [VAL_W-1:0]       pop_value, qry_value;
    logic [SLOT_W-1:0]      pop_slot;
    logic [$clog2(DEPTH):0] count;

    rvvi_net_event_sched #(
        .NREQ(NREQ), .ID_W(ID_W), .VAL_W(VAL_W), .DEPTH(DEPTH), .SLOT_W(SLOT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_id    (req_id),
        .req_value (req_value),
        .slot_tick (slot_tick),
        .pop_valid (pop_valid),
        .pop_ready (pop_ready),
        .pop_id    (pop_id),
        .pop_value (pop_value),
        .pop_slot  (pop_slot),
        .count     (count),
        .qry_id    (qry_id),
        .qry_value (qry_value)
    );

    always #100 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered event list, rotating start index, slot counter.
    typedef struct {
        int unsigned id;
        int unsigned val;
        int unsigned slot;
    } mev_t;

    mev_t        mq[$];
    mev_t        plog[$];
    int          glog[$];
    int          m_ptr;
    int unsigned m_vslot;
    bit          m_tp;
    int unsigned m_sh [64];
    int          last_gnt;

    logic [63:0] s_pv, s_pid, s_pval, s_pslot, s_qry, s_rdy, s_cnt;
    int unsigned exp_slot [5] = '{0, 1, 1, 2, 0};

    task automatic model_clear();
        mq.delete();
        m_ptr   = 0;
        m_vslot = 0;
        m_tp    = 1'b0;
        for (int i = 0; i < 64; i++) m_sh[i] = 0;
        last_gnt = -1;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int              win;
        bit              can;
        logic [NREQ-1:0] exp_rdy;
        mev_t            e;
        @(negedge clk);
        win = -1;
        for (int k = 0; k < NREQ; k++)
            if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        can     = (mq.size() < DEPTH) || (mq.size() > 0 && pop_ready);
        exp_rdy = (win >= 0 && can) ? (NREQ'(1) << win) : '0;
        s_pv = pop_valid; s_pid = pop_id; s_pval = pop_value; s_pslot = pop_slot;
        s_qry = qry_value; s_rdy = req_ready; s_cnt = count;
        chk("req_ready", req_ready, exp_rdy);
        chk("count", count, mq.size());
        chk("pop_valid", pop_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("pop_id", pop_id, mq[0].id);
            chk("pop_value", pop_value, mq[0].val);
            chk("pop_slot", pop_slot, mq[0].slot);
        end
        chk("qry_value", qry_value, m_sh[qry_id]);
        @(posedge clk);
        last_gnt = -1;
        if (mq.size() != 0 && pop_ready) begin
            e = mq.pop_front();
            m_sh[e.id] = e.val;
            plog.push_back(e);
        end
        if (exp_rdy != '0) begin
            m_vslot += (m_tp | slot_tick);
            e.id   = req_id[win*ID_W +: ID_W];
            e.val  = req_value[win*VAL_W +: VAL_W];
            e.slot = m_vslot;
            mq.push_back(e);
            m_tp     = 1'b0;
            m_ptr    = (win + 1) % NREQ;
            last_gnt = win;
            glog.push_back(win);
        end else begin
            m_tp = m_tp | slot_tick;
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [ID_W-1:0] id,
                           input logic [VAL_W-1:0] val);
        req_valid[i] = v;
        req_id[i*ID_W +: ID_W] = id;
        req_value[i*VAL_W +: VAL_W] = val;
    endtask

    // Requesters hold their event until accepted, then may present a new one.
    task automatic upd_reqs(input int pct);
        for (int i = 0; i < NREQ; i++)
            if (!req_valid[i] || i == last_gnt)
                set_req(i, $urandom_range(99) < pct, ID_W'($urandom_range(7)), $urandom);
    endtask

    task automatic reset_dut(input bit do_chk);
        #1 rst_n = 1'b0;
        if (do_chk) begin
            #1;
            chk("rst_count", count, 0);
            chk("rst_pop_valid", pop_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_pop_id", pop_id, 0);
            chk("rst_pop_value", pop_value, 0);
            chk("rst_pop_slot", pop_slot, 0);
            for (int i = 0; i < 64; i++) begin
                qry_id = ID_W'(i);
                #1 chk("rst_qry", qry_value, 0);
            end
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_id = '0; req_value = '0;
        slot_tick = 1'b0; pop_ready = 1'b0; qry_id = '0;
        model_clear();
        #120;
        req_valid = '1;
        #1;
        chk("init_count", count, 0);
        chk("init_pop_valid", pop_valid, 0);
        chk("init_req_ready", req_ready, 0);
        chk("init_pop_slot", pop_slot, 0);
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single event, no tick
        set_req(0, 1'b1, 5, 32'h11);
        cycle();
        chk("single_ready", s_rdy, 1);
        req_valid = '0;
        cycle();
        chk("single_pv", s_pv, 1);
        chk("single_id", s_pid, 5);
        chk("single_val", s_pval, 32'h11);
        chk("single_slot", s_pslot, 0);
        pop_ready = 1'b1;
        cycle();
        pop_ready = 1'b0;
        qry_id = 5;
        cycle();
        chk("single_qry", s_qry, 32'h11);

        // Round robin with all requesters busy
        reset_dut(1'b0);
        glog.delete(); plog.delete();
        pop_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ID_W'(i), $urandom);
        repeat (8) begin
            cycle();
            if (last_gnt >= 0) set_req(last_gnt, 1'b1, ID_W'(last_gnt), $urandom);
        end
        req_valid = '0;
        repeat (3) cycle();
        chk("rr_ngrant", glog.size(), 8);
        chk("rr_npop", plog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size() && k < plog.size(); k++) begin
            chk("rr_grant", glog[k], k % 4);
            chk("rr_pop", plog[k].id, k % 4);
        end

        // Slot stamping and wrap
        reset_dut(1'b0);
        plog.delete();
        pop_ready = 1'b0;
        set_req(0, 1'b1, 1, 32'hA); cycle();
        req_valid = '0; slot_tick = 1'b1; cycle();
        slot_tick = 1'b0;
        set_req(0, 1'b1, 2, 32'hB); cycle();
        set_req(0, 1'b1, 3, 32'hC); cycle();
        set_req(0, 1'b1, 4, 32'hD); slot_tick = 1'b1; cycle();
        slot_tick = 1'b0; req_valid = '0;
        force dut.vslot = {SLOT_W{1'b1}};
        #1 release dut.vslot;
        m_vslot = 32'hFFFF_FFFF;
        set_req(0, 1'b1, 5, 32'hE); slot_tick = 1'b1; cycle();
        slot_tick = 1'b0; req_valid = '0;
        pop_ready = 1'b1;
        repeat (6) cycle();
        pop_ready = 1'b0;
        chk("slot_npop", plog.size(), 5);
        for (int k = 0; k < 5 && k < plog.size(); k++) chk("slot_stamp", plog[k].slot, exp_slot[k]);

        // Full FIFO, then simultaneous push/pop
        reset_dut(1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            set_req(0, 1'b1, ID_W'(k), 32'(k + 100));
            cycle();
        end
        set_req(0, 1'b1, 6'h3F, 32'h200);
        cycle();
        chk("full_count", s_cnt, DEPTH);
        chk("full_ready", s_rdy, 0);
        pop_ready = 1'b1;
        cycle();
        chk("full_pp_ready", s_rdy, 1);
        pop_ready = 1'b0; req_valid = '0;
        cycle();
        chk("full_pp_count", s_cnt, DEPTH);
        pop_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
        pop_ready = 1'b0;

        // Shadow update ordering on one net
        reset_dut(1'b0);
        qry_id = 7;
        set_req(0, 1'b1, 7, 1); cycle();
        set_req(0, 1'b1, 7, 2); cycle();
        req_valid = '0; cycle();
        pop_ready = 1'b1;
        cycle(); chk("shadow_0", s_qry, 0);
        cycle(); chk("shadow_1", s_qry, 1);
        pop_ready = 1'b0;
        cycle(); chk("shadow_2", s_qry, 2);

        // Randomized traffic with alternating drain pressure
        reset_dut(1'b0);
        req_valid = '0;
        upd_reqs(60);
        for (int n = 0; n < 800; n++) begin
            pop_ready = $urandom_range(99) < (((n / 100) % 2) != 0 ? 90 : 30);
            slot_tick = ($urandom_range(3) == 0);
            qry_id    = ID_W'($urandom_range(7));
            cycle();
            upd_reqs(60);
        end

        // Async reset with exactly three events queued and a populated shadow table
        req_valid = '0; slot_tick = 1'b0; pop_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
        pop_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, ID_W'(9 + k), $urandom);
            cycle();
        end
        cycle();
        chk("pre_rst_count", s_cnt, 3);
        reset_dut(1'b1);
        req_valid = '0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
